// File: rtl/rdc_pkg.sv
// Shared types and helpers for the RDC event generator: channel state enum
// and the core/event to flat channel index mapping.
package rdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } chan_state_e;

   function automatic int unsigned chan_idx(input int unsigned core,
                                            input int unsigned evt,
                                            input int unsigned n_events);
      return core * n_events + evt;
   endfunction

endpackage

// File: rtl/rdc_evgen_channel.sv
// One event channel: IDLE/HIGH/GAP sequencer with down-counters for pulse and gap length.
// Repeated sequences are built in when RDC_EVGEN_REPEAT_EN is defined.
module rdc_evgen_channel
   import rdc_pkg::*;
#(
   parameter int WEIGHTS_WIDTH = 8,
   parameter int GAP_WIDTH     = 8
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   enable_i,
   input  logic                   start_i,
   input  logic [WEIGHTS_WIDTH:0] len_i,
   input  logic [GAP_WIDTH-1:0]   gap_i,
`ifdef RDC_EVGEN_REPEAT_EN
   input  logic [3:0]             repeat_i,
`endif
   output logic                   idle_o,
   output logic                   event_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam logic [WEIGHTS_WIDTH:0] LEN_ZERO = {(WEIGHTS_WIDTH+1){1'b0}};
   localparam logic [WEIGHTS_WIDTH:0] LEN_ONE  = {{WEIGHTS_WIDTH{1'b0}}, 1'b1};
   localparam logic [GAP_WIDTH-1:0]   GAP_ZERO = {GAP_WIDTH{1'b0}};
   localparam logic [GAP_WIDTH-1:0]   GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

   chan_state_e            state_q;
   logic [WEIGHTS_WIDTH:0] len_cnt_q;
   logic [GAP_WIDTH-1:0]   gap_cnt_q;
   logic                   event_q;
   logic                   done_q;
   logic [GAP_WIDTH-1:0]   start_gap_s;

`ifdef RDC_EVGEN_REPEAT_EN
   logic [3:0]             rep_q;
   logic [WEIGHTS_WIDTH:0] len_cfg_q;
   logic [GAP_WIDTH-1:0]   gap_cfg_q;
   logic [GAP_WIDTH-1:0]   next_gap_s;

   // A sequence that is followed by another repeat needs at least one low cycle.
   function automatic logic [GAP_WIDTH-1:0] eff_gap(input logic [GAP_WIDTH-1:0] gap,
                                                    input logic more);
      return (more && (gap == GAP_ZERO)) ? GAP_ONE : gap;
   endfunction

   assign start_gap_s = eff_gap(gap_i, repeat_i != 4'd0);
   assign next_gap_s  = eff_gap(gap_cfg_q, rep_q > 4'd1);
`else
   assign start_gap_s = gap_i;
`endif

   assign idle_o  = (state_q == IDLE);
   assign busy_o  = (state_q != IDLE);
   assign event_o = event_q;
   assign done_o  = done_q;

   // Channel sequencer; a low enable aborts silently to IDLE.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         len_cnt_q <= LEN_ZERO;
         gap_cnt_q <= GAP_ZERO;
         event_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef RDC_EVGEN_REPEAT_EN
         rep_q     <= 4'd0;
         len_cfg_q <= LEN_ZERO;
         gap_cfg_q <= GAP_ZERO;
`endif
      end else if (!enable_i) begin
         state_q   <= IDLE;
         len_cnt_q <= LEN_ZERO;
         gap_cnt_q <= GAP_ZERO;
         event_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef RDC_EVGEN_REPEAT_EN
         rep_q     <= 4'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  gap_cnt_q <= start_gap_s;
`ifdef RDC_EVGEN_REPEAT_EN
                  rep_q     <= repeat_i;
                  len_cfg_q <= len_i;
                  gap_cfg_q <= gap_i;
`endif
                  if (len_i != LEN_ZERO) begin
                     state_q   <= HIGH;
                     len_cnt_q <= len_i;
                     event_q   <= 1'b1;
                  end else if (start_gap_s != GAP_ZERO) begin
                     state_q <= GAP;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (len_cnt_q == LEN_ONE) begin
                  event_q   <= 1'b0;
                  len_cnt_q <= LEN_ZERO;
                  if (gap_cnt_q != GAP_ZERO) begin
                     state_q <= GAP;
                  end else begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  len_cnt_q <= len_cnt_q - LEN_ONE;
               end
            end
            GAP: begin
               if (gap_cnt_q != GAP_ONE) begin
                  gap_cnt_q <= gap_cnt_q - GAP_ONE;
`ifdef RDC_EVGEN_REPEAT_EN
               end else if (rep_q != 4'd0) begin
                  rep_q     <= rep_q - 4'd1;
                  gap_cnt_q <= next_gap_s;
                  if (len_cfg_q != LEN_ZERO) begin
                     state_q   <= HIGH;
                     len_cnt_q <= len_cfg_q;
                     event_q   <= 1'b1;
                  end else if (next_gap_s == GAP_ZERO) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
`endif
               end else begin
                  state_q   <= IDLE;
                  gap_cnt_q <= GAP_ZERO;
                  done_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               event_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rdc_event_gen.sv
// RDC event generator top: command decode, handshake and error pulse around per-channel sequencers.
// Define RDC_EVGEN_REPEAT_EN to add cmd_repeat_i and repeated pulse sequences.
module rdc_event_gen
   import rdc_pkg::*;
#(
   parameter  int N_CORES       = 2,
   parameter  int CORE_EVENTS   = 4,
   parameter  int WEIGHTS_WIDTH = 8,
   parameter  int GAP_WIDTH     = 8,
   localparam int CORE_W        = (N_CORES > 1) ? $clog2(N_CORES) : 1,
   localparam int EVENT_W       = (CORE_EVENTS > 1) ? $clog2(CORE_EVENTS) : 1,
   localparam int N_CH          = N_CORES * CORE_EVENTS
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     enable_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [CORE_W-1:0]        cmd_core_i,
   input  logic [EVENT_W-1:0]       cmd_event_i,
   input  logic [WEIGHTS_WIDTH:0]   cmd_len_i,
   input  logic [GAP_WIDTH-1:0]     cmd_gap_i,
`ifdef RDC_EVGEN_REPEAT_EN
   input  logic [3:0]               cmd_repeat_i,
`endif
   output logic [CORE_EVENTS-1:0]   events_o [N_CORES],
   output logic [N_CH-1:0]          busy_o,
   output logic [N_CH-1:0]          done_o,
   output logic                     err_o
);

   localparam int unsigned NC_U = N_CORES;
   localparam int unsigned NE_U = CORE_EVENTS;

   int unsigned     core_s;
   int unsigned     event_s;
   int unsigned     target_s;
   logic            oor_s;
   logic            target_idle_s;
   logic            accept_s;
   logic            err_q;
   logic [N_CH-1:0] idle_s;

   assign core_s      = 32'(cmd_core_i);
   assign event_s     = 32'(cmd_event_i);
   assign target_s    = chan_idx(core_s, event_s, NE_U);
   assign oor_s       = (core_s >= NC_U) || (event_s >= NE_U);
   assign cmd_ready_o = enable_i && (oor_s || target_idle_s);
   assign accept_s    = cmd_valid_i && cmd_ready_o;
   assign err_o       = err_q;

   // Idle status of the addressed channel; out-of-range indices select nothing.
   always_comb begin
      target_idle_s = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         target_idle_s = target_idle_s | (idle_s[i] && (target_s == 32'(i)));
      end
   end

   // Out-of-range commands are swallowed and flagged one cycle later.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         err_q <= 1'b0;
      end else if (!enable_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept_s && oor_s;
      end
   end

   for (genvar c = 0; c < N_CORES; c++) begin : g_core
      for (genvar e = 0; e < CORE_EVENTS; e++) begin : g_evt
         localparam int unsigned IDX = chan_idx(c, e, NE_U);
         rdc_evgen_channel #(
            .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
            .GAP_WIDTH     (GAP_WIDTH)
         ) u_chan (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .enable_i (enable_i),
            .start_i  (accept_s && !oor_s && (target_s == IDX)),
            .len_i    (cmd_len_i),
            .gap_i    (cmd_gap_i),
`ifdef RDC_EVGEN_REPEAT_EN
            .repeat_i (cmd_repeat_i),
`endif
            .idle_o   (idle_s[IDX]),
            .event_o  (events_o[c][e]),
            .busy_o   (busy_o[IDX]),
            .done_o   (done_o[IDX])
         );
      end
   end

endmodule
